// File: rtl/gate_bist.sv
// Built-in self-test sequencer: walks every input vector through an external gate and checks it against TRUTH.
// Optional first-failure capture outputs are enabled with `define GATE_BIST_FAIL_CAPTURE_EN.
module gate_bist #(
    parameter int unsigned               N_IN   = 2,
    parameter logic [(1 << N_IN) - 1:0]  TRUTH  = 4'b1000,
    parameter int unsigned               SETTLE = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    ,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    state_t          state, state_n;
    logic [N_IN-1:0] vec, vec_n;
    logic [3:0]      cnt, cnt_n;
    logic            busy_n, done_n, pass_n;
    logic [N_IN:0]   err_n;
    logic            mism;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic            fv_n;
    logic [N_IN-1:0] ff_n;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vec        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            first_fail <= '0;
`endif
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            cnt        <= cnt_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
            fail_valid <= fv_n;
            first_fail <= ff_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_count;
        mism    = 1'b0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        fv_n    = fail_valid;
        ff_n    = first_fail;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    vec_n   = '0;
                    cnt_n   = SETTLE_C;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                    fv_n    = 1'b0;
                    ff_n    = '0;
`endif
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    mism = (dut_out != TRUTH[vec]);
                    if (mism) begin
                        err_n = err_count + 1'b1;
                    end
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                    if (mism && !fail_valid) begin
                        fv_n = 1'b1;
                        ff_n = vec;
                    end
`endif
                    // pass is taken from the post-increment count so the final compare is included
                    if (vec == LAST_VEC) begin
                        state_n = DONE;
                        vec_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end else begin
                        vec_n = vec + 1'b1;
                        cnt_n = SETTLE_C;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dut_in = (state == RUN) ? vec : '0;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (SETTLE=0 and SETTLE=2) driven by a table-based gate model.
module tb_gate_bist;

    localparam logic [3:0] AND_TT = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_a [2];
    logic       dout_a  [2];
    logic [1:0] din_a   [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       pass_a  [2];
    logic [2:0] err_a   [2];
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic       fv_a    [2];
    logic [1:0] ff_a    [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_bist #(.N_IN(2), .TRUTH(AND_TT), .SETTLE(0)) u_s0 (
        .clk(clk), .reset_n(reset_n), .start(start_a[0]), .dut_in(din_a[0]),
        .dut_out(dout_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
        .err_count(err_a[0])
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv_a[0]), .first_fail(ff_a[0])
`endif
    );

    gate_bist #(.N_IN(2), .TRUTH(AND_TT), .SETTLE(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .start(start_a[1]), .dut_in(din_a[1]),
        .dut_out(dout_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
        .err_count(err_a[1])
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv_a[1]), .first_fail(ff_a[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int s, input string tag);
        chk({tag, "_busy"}, 32'(busy_a[s]), 0);
        chk({tag, "_done"}, 32'(done_a[s]), 0);
        chk({tag, "_pass"}, 32'(pass_a[s]), 0);
        chk({tag, "_err"},  32'(err_a[s]), 0);
        chk({tag, "_din"},  32'(din_a[s]), 0);
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        chk({tag, "_fv"},   32'(fv_a[s]), 0);
        chk({tag, "_ff"},   32'(ff_a[s]), 0);
`endif
    endtask

    // One full run on instance s with the gate behaving as table tab.
    task automatic run(input int s, input logic [3:0] tab, input bit glitch, input bit hold);
        int st, k, exp_err, exp_ff;
        bit exp_fv;
        st = (s == 0) ? 0 : 2;
        exp_err = 0; exp_fv = 0; exp_ff = 0;
        for (int v = 0; v < 4; v++) begin
            if (tab[v] != AND_TT[v]) begin
                exp_err++;
                if (!exp_fv) begin
                    exp_fv = 1;
                    exp_ff = v;
                end
            end
        end
        @(negedge clk);
        start_a[s] = 1'b1;
        @(posedge clk);
        for (int rel = 1; rel <= 4 * (st + 1); rel++) begin
            @(negedge clk);
            if (!hold) start_a[s] = 1'b0;
            k = (rel - 1) / (st + 1);
            chk("run_busy", 32'(busy_a[s]), 1);
            chk("run_done", 32'(done_a[s]), 0);
            chk("run_din",  32'(din_a[s]), k);
            if (rel == 1) chk("run_err_clr", 32'(err_a[s]), 0);
            if ((rel % (st + 1)) == 0 || !glitch) dout_a[s] = tab[k];
            else dout_a[s] = (($urandom_range(0, 1)) != 0) ? ~tab[k] : tab[k];
        end
        @(negedge clk);
        chk("end_done", 32'(done_a[s]), 1);
        chk("end_busy", 32'(busy_a[s]), 0);
        chk("end_err",  32'(err_a[s]), exp_err);
        chk("end_pass", 32'(pass_a[s]), (exp_err == 0) ? 1 : 0);
        chk("end_din",  32'(din_a[s]), 0);
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        chk("end_fv",   32'(fv_a[s]), exp_fv);
        chk("end_ff",   32'(ff_a[s]), exp_ff);
`endif
        start_a[s] = 1'b0;
        dout_a[s] = $urandom_range(0, 1);
        repeat (2) @(negedge clk);
        chk("hold_done", 32'(done_a[s]), 1);
        chk("hold_busy", 32'(busy_a[s]), 0);
        chk("hold_err",  32'(err_a[s]), exp_err);
    endtask

    initial begin
        int waited;
        start_a[0] = 1'b0; start_a[1] = 1'b0;
        dout_a[0]  = 1'b0; dout_a[1]  = 1'b0;
        #1;
        chk_idle_outputs(0, "rst0");
        chk_idle_outputs(1, "rst1");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run(0, 4'b1000, 1'b0, 1'b0);   // correct AND
        run(0, 4'b1110, 1'b0, 1'b0);   // OR in place of AND
        run(0, 4'b1111, 1'b0, 1'b0);   // stuck at 1
        run(0, 4'b0000, 1'b0, 1'b0);   // stuck at 0
        run(1, 4'b1000, 1'b1, 1'b0);   // settle 2 with glitches off-sample
        run(0, 4'b1000, 1'b0, 1'b1);   // start held high for whole run
        run(1, 4'b0111, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run(i % 2, 4'($urandom_range(0, 15)), 1'b1, 1'($urandom_range(0, 1)));
        end

        // asynchronous reset mid-run while vector 2 is applied
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        dout_a[0] = 1'b0;
        waited = 0;
        while (din_a[0] != 2'd2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_reach_vec2", 32'(din_a[0]), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs(0, "midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs(0, "postrst");
        run(0, 4'b1010, 1'b0, 1'b0);
        run(0, 4'b1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Synthesizable built-in self-test sequencer for small combinational gates; the in-hardware counterpart of a directed truth-table bench.
- Drives every input vector 0..2^N_IN-1 in order into an external gate under test, samples the gate's output, and compares it against a parameterized truth table.
- Counts mismatches and reports pass/fail.
- Sits beside a student gate on the FPGA lab board; start comes from a pushbutton synchronizer, results go to LEDs.

Parameters:
- N_IN, 2, number of gate inputs, legal range 1..6.
- TRUTH, 4'b1000, expected output table, width 2^N_IN; bit k is the expected output for input vector k. The default is the 2-input AND.
- SETTLE, 0, extra cycles each vector is held before sampling, legal range 0..15.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous, one-cycle or level; begins a run.
- dut_in  out  N_IN  vector driven to the gate under test.
- dut_out  in  1  gate response, assumed synchronous to clk.
- busy  out  1  run in progress.
- done  out  1  run complete, results valid.
- pass  out  1  done and err_count==0.
- err_count  out  N_IN+1  mismatch count for the last run.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_count=0.
  - vec=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - dut_in=0.
  - start=1 at edge E0 -> RUN, vec<=0, cnt<=SETTLE, err_count<=0, done<=0, pass<=0, busy<=1.
- RUN:
  - dut_in=vec, driven from a register, glitch-free.
  - Each edge: if cnt!=0, cnt<=cnt-1.
  - Otherwise compare dut_out with TRUTH[vec]; on mismatch err_count<=err_count+1.
  - Then, if vec==2^N_IN-1 -> DONE; else vec<=vec+1, cnt<=SETTLE.
  - Vector k is applied from edge E0+k(SETTLE+1) and sampled at edge E0+(k+1)(SETTLE+1).
  - The final compare happens at edge E0+2^N_IN(SETTLE+1). The err_count increment and the DONE entry take effect on that same edge.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - dut_in=0. err_count holds.
  - start=1 -> restart exactly as from IDLE: results clear on the accepting edge.
- start while in RUN is ignored; there is no restart mid-run.
- err_count cannot overflow, since its maximum is 2^N_IN and the width is N_IN+1.
- All outputs are registered except dut_in, which is a registered vec gated to 0 outside RUN.
- Reset mid-run: immediate return to the reset values above. No partial results are retained.
- dut_out is sampled only at compare edges; its value at other edges has no effect.

Optional Feature:
- Macro: GATE_BIST_FAIL_CAPTURE_EN.
- Defined: adds two outputs.
  - fail_valid  out  1.
  - first_fail  out  N_IN.
  - At the first mismatch of a run, first_fail<=vec and fail_valid<=1. Later mismatches do not change them.
  - Both clear to 0 on reset and on run start.
  - Both hold through DONE.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Correct AND gate, SETTLE=0: pulse start -> busy=1 for 4 cycles; done=1 after 4th edge following start; pass=1, err_count=0; dut_in sequence 0,1,2,3 then 0.
2. OR gate in place of AND, TRUTH=4'b1000: run -> err_count=2, pass=0, done=1; with GATE_BIST_FAIL_CAPTURE_EN: first_fail=1, fail_valid=1.
3. dut_out tied 1: run -> err_count=3, pass=0; first_fail=0 (if enabled). Then tie dut_out to 0 -> err_count=1.
4. SETTLE=2, correct AND: done rises after edge E0+12; each vector held exactly 3 cycles; glitch dut_out to wrong value on non-sample cycles -> err_count still 0.
5. Hold start high for whole run -> exactly one run. Restart from DONE clears err_count on the accepting edge, and done drops the same edge.
6. Assert reset_n=0 asynchronously mid-clock during vec=2 -> all outputs 0 immediately. After release, start -> full clean run with 4 vectors and correct results.
